alu_iter_exec: RTL and testbench

- Execute-stage consumer of the 4-bit ALU operation codes produced by the decoder: the receiving end of the decoder→ALU op interface.
- Accepts one operation with two operands over a valid/ready handshake.
- Logic and arithmetic ops complete in 1 cycle. SLL/SRL/SRA use an iterative 1-bit-per-cycle shifter to save area.
- Result is presented on a valid/ready output that holds under backpressure. Sits between issue and writeback.

---
 rtl/alu_iter_exec.sv | 163 ++++++++++++++++
 tb/tb_alu_iter_exec.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU consuming decoder op codes. Logic and arithmetic ops
// complete in one cycle; SLL/SRL/SRA use an iterative 1-bit-per-cycle shifter.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. Input side: in_ready is high only in IDLE, and flush blocks acceptance
// even when in_ready is high. Output side: out_valid, out_result and out_err
// hold steady until out_ready is seen high; flush withdraws out_valid.
module alu_iter_exec #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_SRL  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLTU = 4'h9;
  localparam logic [3:0] OP_SEQ  = 4'hA;
  localparam logic [3:0] OP_SNE  = 4'hB;
  localparam logic [3:0] OP_SGE  = 4'hC;
  localparam logic [3:0] OP_SGEU = 4'hD;
  localparam logic [3:0] OP_NONE = 4'hE;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   res_q;      // shift accumulator while in SHIFT, result in OUT
  logic              err_q;
  logic [SHW-1:0]    cnt_q;
  logic [3:0]        op_q;

  logic [SHW-1:0]    shamt;
  logic              is_shift;
  logic              shift_start;
  logic              accept;
  logic [XLEN-1:0]   alu_res;
  logic              alu_err;
  logic [XLEN-1:0]   shift_step;
  logic              lt_s, lt_u;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign out_result = res_q;
  assign out_err    = err_q;
  assign dbg_state  = state_q;

  assign shamt       = in_b[SHW-1:0];
  assign is_shift    = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);
  assign accept      = in_valid && in_ready && !flush;
  assign shift_start = is_shift && (shamt != '0);
  assign lt_s        = $signed(in_a) < $signed(in_b);
  assign lt_u        = in_a < in_b;

  // Single-cycle ALU result; shifts by zero pass operand A through unchanged.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    unique case (in_op)
      OP_ADD:  alu_res = in_a + in_b;
      OP_SUB:  alu_res = in_a - in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLL, OP_SRA, OP_SRL: alu_res = in_a;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_SEQ:  alu_res = {{(XLEN-1){1'b0}}, in_a == in_b};
      OP_SNE:  alu_res = {{(XLEN-1){1'b0}}, in_a != in_b};
      OP_SGE:  alu_res = {{(XLEN-1){1'b0}}, !lt_s};
      OP_SGEU: alu_res = {{(XLEN-1){1'b0}}, !lt_u};
      OP_NONE: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One-bit shift of the accumulator according to the latched op.
  always_comb begin
    shift_step = res_q;
    unique case (op_q)
      OP_SLL:  shift_step = {res_q[XLEN-2:0], 1'b0};
      OP_SRL:  shift_step = {1'b0, res_q[XLEN-1:1]};
      OP_SRA:  shift_step = {res_q[XLEN-1], res_q[XLEN-1:1]};
      default: shift_step = res_q;
    endcase
  end

  // Next-state logic; flush overrides everything, including out_ready.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = shift_start ? S_SHIFT : S_OUT;
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: capture result or shift operands, then iterate the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= OP_NONE;
    end else if (flush) begin
      res_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q <= in_op;
            if (shift_start) begin
              res_q <= in_a;
              err_q <= 1'b0;
              cnt_q <= shamt;
            end else begin
              res_q <= alu_res;
              err_q <= alu_err;
            end
          end
        end
        S_SHIFT: begin
          res_q <= shift_step;
          cnt_q <= cnt_q - SHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Directed bench for alu_iter_exec with hand-computed expected results.
module tb_alu_iter_exec;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_err;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [XLEN:0] exp_q[$];   // {err, result}

  alu_iter_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one op with out_ready high, measure latency and compare result.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                        input logic exp_err, input int exp_lat);
    logic [XLEN:0] e;
    int lat;
    exp_q.push_back({exp_err, exp_res});
    out_ready = 1'b1;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    check({tag, "_rdy0"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      check({tag, "_busy"}, in_ready, 0);
      tick();
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, out_result, e[XLEN-1:0]);
    check({tag, "_err"}, out_err, e[XLEN]);
    tick();
    check({tag, "_rdy_after"}, in_ready, 1);
    check({tag, "_ov_after"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 4'h0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #2;
    check("rst_ov", out_valid, 0);
    check("rst_res", out_result, 0);
    check("rst_err", out_err, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy", in_ready, 1);

    // Single-cycle ops
    run_op("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("sub",      4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("and",      4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
    run_op("or",       4'h3, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    run_op("slt",      4'h8, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
    run_op("sltu",     4'h9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("sge",      4'hC, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1);
    run_op("sgeu",     4'hD, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1);
    run_op("seq",      4'hA, 32'h1234, 32'h1234, 32'h1, 1'b0, 1);
    run_op("sne",      4'hB, 32'h1234, 32'h1234, 32'h0, 1'b0, 1);
    run_op("illegal",  4'hF, 32'h5555, 32'h7777, 32'h0, 1'b1, 1);
    run_op("none",     4'hE, 32'h5555, 32'h7777, 32'h0, 1'b0, 1);

    // Iterative shifts
    run_op("sra4",     4'h6, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5);
    run_op("srl4",     4'h7, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b0, 5);
    run_op("sll0",     4'h5, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1);
    run_op("sll3_hi",  4'h5, 32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 1'b0, 4);
    run_op("sll31",    4'h5, 32'h0000_0003, 32'h0000_001F, 32'h8000_0000, 1'b0, 32);

    // Backpressure: result holds, input pulses ignored, one result only
    out_ready = 1'b0;
    in_op = 4'h4; in_a = 32'hF0F0_F0F0; in_b = 32'hFFFF_0000; in_valid = 1'b1;
    tick();
    in_op = 4'h0; in_a = 32'h1; in_b = 32'h1;
    for (int i = 0; i < 5; i++) begin
      check("bp_ov", out_valid, 1);
      check("bp_res", out_result, 32'h0F0F_F0F0);
      check("bp_rdy", in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_hold_last", out_result, 32'h0F0F_F0F0);
    out_ready = 1'b1;
    tick();
    check("bp_rel_ov", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_once", out_valid, 0);
      tick();
    end

    // Flush mid-shift at cycle 10
    out_ready = 1'b1;
    in_op = 4'h5; in_a = 32'h1; in_b = 32'd31; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) begin
      check("fl_no_ov", out_valid, 0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_rdy11", in_ready, 1);
    check("fl_ov11", out_valid, 0);
    repeat (25) begin
      check("fl_discard", out_valid, 0);
      tick();
    end

    // Flush coinciding with in_valid in IDLE: nothing accepted
    in_op = 4'h0; in_a = 32'h9; in_b = 32'h9; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("fl_idle_rdy", in_ready, 1);
    check("fl_idle_ov", out_valid, 0);

    // Flush beats out_ready=0 hold in OUT
    out_ready = 1'b0;
    in_op = 4'h0; in_a = 32'h2; in_b = 32'h2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fl_out_ov", out_valid, 1);
    check("fl_out_res", out_result, 32'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_out_gone", out_valid, 0);
    check("fl_out_rdy", in_ready, 1);

    // Reset asserted mid-shift
    out_ready = 1'b1;
    in_op = 4'h5; in_a = 32'h1; in_b = 32'd31; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("rs_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rs_ov", out_valid, 0);
    check("rs_res", out_result, 0);
    check("rs_err", out_err, 0);
    check("rs_state", dbg_state, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (40) begin
      check("rs_no_partial", out_valid, 0);
      tick();
    end
    run_op("add_after_rst", 4'h0, 32'd5, 32'd7, 32'd12, 1'b0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
